// File: rtl/roll_decimation_ctrl_pkg.sv
// Shared definitions for the roll-mode decimation controller: state
// encoding and default datapath dimensions.
package roll_decimation_ctrl_pkg;

  localparam int SAMPLE_W_DEF = 12;
  localparam int ACC_W_DEF    = 42;
  localparam int PRE_W_DEF    = 16;
  localparam int H_RES_DEF    = 640;
  localparam int COL_W_DEF    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DIV   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/roll_decimation_ctrl_divider.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH clocks per
// division. A new start always restarts the unit, abandoning any division
// still in flight, so callers can simply ignore a result they no longer want.
module seq_divider
  import roll_decimation_ctrl_pkg::*;
#(
  parameter int WIDTH = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int IW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [IW-1:0]    iter_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  // Iteration register: load on start, then restore-or-keep for WIDTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      iter_q <= IW'(WIDTH);
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      if (trial[WIDTH]) begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
      iter_q <= iter_q - IW'(1);
      if (iter_q == IW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/roll_decimation_ctrl.sv
// Roll-mode decimation controller. Sums each window of `prescaler` samples,
// divides by the window length with a sequential divider and hands the
// averaged point, tagged with a wrapping roll column, to the screen writer.
module roll_decimation_ctrl
  import roll_decimation_ctrl_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int PRE_W    = PRE_W_DEF,
  parameter int H_RES    = H_RES_DEF,
  parameter int COL_W    = COL_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PRE_W-1:0]    prescaler,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic [COL_W-1:0]    out_col,
  output logic                busy,
  output logic                overrun,
  input  logic                clr_overrun
);

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0]    acc;
  logic [PRE_W-1:0]    cnt;
  logic [PRE_W-1:0]    pre_lat;
  logic [PRE_W-1:0]    pre_eff;
  logic [PRE_W:0]      cnt_inc;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    divisor_ext;
  logic [SAMPLE_W-1:0] quot_sat;
  logic                running;
  logic                win_done;
  logic                div_start;
  logic                bypass;
  logic                drop;
  logic                accept;
  logic                load_quot;
  logic                div_busy;
  logic                div_done;
  logic [ACC_W-1:0]    div_quot;

  // Window bookkeeping and hand-off decisions; a window can only be handed
  // over when nothing is in the divider and no point is waiting (ACCUM).
  always_comb begin
    pre_eff     = (prescaler == '0) ? PRE_W'(1) : prescaler;
    cnt_inc     = {1'b0, cnt} + (PRE_W+1)'(1);
    sum         = acc + ACC_W'(sample);
    divisor_ext = ACC_W'(pre_lat);
    running     = enable && (state != ST_IDLE);
    win_done    = running && sample_valid && (cnt_inc == {1'b0, pre_lat});
    div_start   = win_done && (state == ST_ACCUM) && (pre_lat != PRE_W'(1));
    bypass      = win_done && (state == ST_ACCUM) && (pre_lat == PRE_W'(1));
    drop        = win_done && (state != ST_ACCUM);
    accept      = enable && (state == ST_OUT) && out_ready;
    load_quot   = enable && (state == ST_DIV) && div_done;
    quot_sat    = (|div_quot[ACC_W-1:SAMPLE_W]) ? '1 : div_quot[SAMPLE_W-1:0];
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_ACCUM;
        ST_ACCUM: begin
          if (div_start) begin
            state_nxt = ST_DIV;
          end else if (bypass) begin
            state_nxt = ST_OUT;
          end
        end
        ST_DIV:   if (div_done) state_nxt = ST_OUT;
        ST_OUT:   if (out_ready) state_nxt = ST_ACCUM;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator runs in every active state so sampling never stalls behind
  // the divider; the prescaler is re-latched only at window boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      pre_lat <= PRE_W'(1);
    end else if (!running) begin
      acc <= '0;
      cnt <= '0;
      if (enable) begin
        pre_lat <= pre_eff;
      end
    end else if (sample_valid) begin
      if (win_done) begin
        acc     <= '0;
        cnt     <= '0;
        pre_lat <= pre_eff;
      end else begin
        acc <= sum;
        cnt <= cnt_inc[PRE_W-1:0];
      end
    end
  end

  // Output point and roll column; the column survives enable drops so the
  // trace resumes where it left off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_col  <= '0;
    end else if (!enable) begin
      out_data <= '0;
    end else begin
      if (bypass) begin
        out_data <= sample;
      end else if (load_quot) begin
        out_data <= quot_sat;
      end
      if (accept) begin
        out_col <= (out_col == COL_W'(H_RES-1)) ? '0 : out_col + COL_W'(1);
      end
    end
  end

  // Sticky overrun flag; a drop in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign out_valid = (state == ST_OUT);
  assign busy      = div_busy && (state == ST_DIV);

  seq_divider #(
    .WIDTH (ACC_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum),
    .divisor  (divisor_ext),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

endmodule

// File: tb/tb_roll_decimation_ctrl.sv
// Self-checking bench for roll_decimation_ctrl: a window-level reference
// model checked every cycle, directed scenarios with literal expectations,
// and a randomized phase.
module tb_roll_decimation_ctrl;

  localparam int ACC_W = 42;
  localparam int H_RES = 640;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] prescaler;
  logic        sample_valid;
  logic [11:0] sample;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [9:0]  out_col;
  logic        busy;
  logic        overrun;
  logic        clr_overrun;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  bit     m_active = 0;
  bit     m_outv   = 0;
  bit     m_ovr    = 0;
  int     m_outd   = 0;
  int     m_col    = 0;
  int     m_rem    = 0;
  int     m_val    = 0;
  int     m_pre    = 1;
  int     m_cnt    = 0;
  longint m_acc    = 0;

  roll_decimation_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .prescaler    (prescaler),
    .sample_valid (sample_valid),
    .sample       (sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_col      (out_col),
    .busy         (busy),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_active = 0; m_outv = 0; m_ovr = 0; m_outd = 0; m_col = 0;
    m_rem = 0; m_val = 0; m_pre = 1; m_cnt = 0; m_acc = 0;
  endtask

  // One clock of the reference: windows of m_pre samples, a point appearing
  // ACC_W+1 clocks after its window closes (or next clock when m_pre is 1),
  // windows closing while a point is outstanding are lost.
  task automatic modelStep();
    bit pend;
    bit drop;
    longint total;
    int p;
    drop = 0;
    p = (int'(prescaler) == 0) ? 1 : int'(prescaler);
    if (!enable) begin
      m_active = 0; m_acc = 0; m_cnt = 0; m_outv = 0; m_outd = 0; m_rem = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_pre = p;
    end else begin
      pend = m_outv || (m_rem != 0);
      if (m_outv && out_ready) begin
        m_outv = 0;
        m_col = (m_col + 1) % H_RES;
      end
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_outv = 1;
          m_outd = m_val;
        end
      end
      if (sample_valid) begin
        total = m_acc + longint'(sample);
        if (m_cnt + 1 == m_pre) begin
          if (pend) begin
            drop = 1;
          end else if (m_pre == 1) begin
            m_outv = 1;
            m_outd = int'(sample);
          end else begin
            m_rem = ACC_W + 1;
            m_val = (total / m_pre > 4095) ? 4095 : int'(total / m_pre);
          end
          m_acc = 0;
          m_cnt = 0;
          m_pre = p;
        end else begin
          m_acc = total;
          m_cnt++;
        end
      end
    end
    if (drop) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput();
    expect_eq("out_valid", int'(out_valid), int'(m_outv));
    expect_eq("out_data", int'(out_data), m_outd);
    expect_eq("out_col", int'(out_col), m_col);
    expect_eq("busy", int'(busy), (m_rem >= 2) ? 1 : 0);
    expect_eq("overrun", int'(overrun), int'(m_ovr));
  endtask

  always @(negedge clk) begin
    if (chk_en) checkOutput();
  end

  task automatic applyStimulus(input bit en, input int pre, input bit sv,
                               input int s, input bit rdy, input bit clr);
    enable       = en;
    prescaler    = 16'(pre);
    sample_valid = sv;
    sample       = 12'(s);
    out_ready    = rdy;
    clr_overrun  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int limit, output int cycles);
    bit found = 0;
    cycles = -1;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        cycles = i;
      end else begin
        @(posedge clk);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: out_valid got 0 expected 1 within %0d cycles", name, limit);
    end
  endtask

  int lat;
  int pre_tab[7] = '{0, 1, 2, 3, 4, 7, 16};
  int cur_pre;

  initial begin
    rst_n = 0;
    enable = 0; prescaler = 0; sample_valid = 0; sample = 0;
    out_ready = 0; clr_overrun = 0;
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1;
    chk_en = 1;

    // Reset state.
    @(negedge clk);
    expect_eq("rst_valid", int'(out_valid), 0);
    expect_eq("rst_data", int'(out_data), 0);
    expect_eq("rst_col", int'(out_col), 0);
    expect_eq("rst_busy", int'(busy), 0);
    expect_eq("rst_overrun", int'(overrun), 0);

    // Basic average with latency measurement.
    applyStimulus(1, 4, 0, 0, 0, 0);
    applyStimulus(1, 4, 1, 100, 0, 0);
    applyStimulus(1, 4, 1, 200, 0, 0);
    applyStimulus(1, 4, 1, 300, 0, 0);
    applyStimulus(1, 4, 1, 400, 0, 0);
    sample_valid = 0;
    wait_valid("avg4_wait", 100, lat);
    expect_eq("avg4_latency", lat, 43);
    expect_eq("avg4_data", int'(out_data), 250);
    expect_eq("avg4_col", int'(out_col), 0);
    applyStimulus(1, 4, 0, 0, 1, 0);

    // Bypass with prescaler 0, then prescaler 1.
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("idle_col_kept", int'(out_col), 1);
    expect_eq("idle_data", int'(out_data), 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 'hABC, 0, 0);
    sample_valid = 0;
    @(negedge clk);
    expect_eq("bypass0_valid", int'(out_valid), 1);
    expect_eq("bypass0_data", int'(out_data), 'hABC);
    applyStimulus(1, 1, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 'h123, 0, 0);
    sample_valid = 0;
    @(negedge clk);
    expect_eq("bypass1_valid", int'(out_valid), 1);
    expect_eq("bypass1_data", int'(out_data), 'h123);
    applyStimulus(1, 1, 0, 0, 1, 0);

    // Enable drop during a division.
    applyStimulus(0, 2, 0, 0, 0, 0);
    applyStimulus(1, 2, 0, 0, 0, 0);
    applyStimulus(1, 2, 1, 1000, 0, 0);
    applyStimulus(1, 2, 1, 3000, 0, 0);
    repeat (10) applyStimulus(1, 2, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("mid_div_busy", int'(busy), 1);
    applyStimulus(0, 2, 0, 0, 0, 0);
    @(negedge clk);
    expect_eq("drop_en_valid", int'(out_valid), 0);
    expect_eq("drop_en_busy", int'(busy), 0);
    expect_eq("drop_en_col", int'(out_col), 3);

    // Asynchronous reset during a division.
    applyStimulus(1, 2, 0, 0, 0, 0);
    applyStimulus(1, 2, 1, 500, 0, 0);
    applyStimulus(1, 2, 1, 700, 0, 0);
    repeat (5) applyStimulus(1, 2, 0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    expect_eq("arst_valid", int'(out_valid), 0);
    expect_eq("arst_data", int'(out_data), 0);
    expect_eq("arst_col", int'(out_col), 0);
    expect_eq("arst_busy", int'(busy), 0);
    expect_eq("arst_overrun", int'(overrun), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1;

    // Backpressure: point held, later windows dropped, overrun cleared.
    applyStimulus(1, 50, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) applyStimulus(1, 50, 1, $urandom_range(0, 4095), 0, 0);
    @(negedge clk);
    expect_eq("bp_overrun", int'(overrun), 1);
    expect_eq("bp_valid_held", int'(out_valid), 1);
    applyStimulus(1, 50, 0, 0, 1, 1);
    @(negedge clk);
    expect_eq("bp_clr_overrun", int'(overrun), 0);
    expect_eq("bp_accepted", int'(out_valid), 0);
    applyStimulus(1, 50, 0, 0, 0, 0);

    // Prescaler change mid-window.
    applyStimulus(0, 8, 0, 0, 1, 0);
    applyStimulus(1, 8, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(1, 8, 1, 10 * i, 1, 0);
    for (int i = 4; i <= 8; i++) applyStimulus(1, 2, 1, 10 * i, 1, 0);
    sample_valid = 0;
    wait_valid("pchg_first", 100, lat);
    expect_eq("pchg_first_data", int'(out_data), 45);
    applyStimulus(1, 2, 1, 1000, 1, 0);
    applyStimulus(1, 2, 1, 2001, 1, 0);
    sample_valid = 0;
    wait_valid("pchg_second", 100, lat);
    expect_eq("pchg_second_data", int'(out_data), 1500);
    applyStimulus(1, 2, 0, 0, 1, 0);

    // Column wrap over 641 accepted points.
    applyStimulus(0, 2, 0, 0, 0, 0);
    rst_n = 0;
    applyStimulus(0, 2, 0, 0, 0, 0);
    rst_n = 1;
    applyStimulus(1, 2, 0, 0, 0, 0);
    for (int k = 0; k <= 640; k++) begin
      applyStimulus(1, 2, 1, $urandom_range(0, 4095), 0, 0);
      applyStimulus(1, 2, 1, $urandom_range(0, 4095), 0, 0);
      sample_valid = 0;
      wait_valid("wrap_wait", 60, lat);
      expect_eq("wrap_col", int'(out_col), k % H_RES);
      applyStimulus(1, 2, 0, 0, 1, 0);
    end

    // Randomized traffic.
    cur_pre = 3;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) cur_pre = pre_tab[$urandom_range(0, 6)];
      applyStimulus(($urandom_range(0, 63) != 0), cur_pre,
                    ($urandom_range(0, 2) != 0), $urandom_range(0, 4095),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/roll_decimation_ctrl.md
Name: roll_decimation_ctrl

Overview:
- Roll-mode decimation controller in front of the display writer.
- Averages every `prescaler` consecutive ADC samples into one 12-bit display point.
- Uses a sequential restoring divider, not a combinational one.
- Hands each point to the screen writer with a valid/ready handshake and tags it with a wrapping roll column.

Parameters:
- SAMPLE_W, 12, input sample and output point width.
- ACC_W, 42, accumulator / dividend width; also the number of divider iterations.
- PRE_W, 16, prescaler width.
- H_RES, 640, number of roll columns.
- COL_W, 10, column index width (ceil(log2(H_RES))).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run; low returns to IDLE at the next clock and discards partial work
- prescaler  in  PRE_W  samples per output point; 0 treated as 1
- sample_valid  in  1  sample strobe
- sample  in  SAMPLE_W  unsigned sample
- out_valid  out  1  point available
- out_ready  in  1  writer accepts the point
- out_data  out  SAMPLE_W  averaged point
- out_col  out  COL_W  roll column of out_data
- busy  out  1  divider running
- overrun  out  1  sticky: a window was dropped
- clr_overrun  in  1  clears overrun

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_col=0, busy=0, overrun=0.
  - Accumulator=0, sample count=0, pre_lat=1, state=IDLE.
- Prescaler latching:
  - pre_lat = max(prescaler,1), captured on entering ACCUM and at every window start.
  - Prescaler changes mid-window take effect at the next window only.
- Accumulate (independent of the divider):
  - On sample_valid in ACCUM: acc += zero-extended sample; cnt++.
  - When cnt reaches pre_lat: window complete. Same cycle: snapshot acc+sample into the dividend, reset acc=0 and cnt=0, re-latch prescaler.
  - The next window's accumulation starts immediately after.
- Divider hand-off on window complete:
  - Divider idle and no point pending: start division.
  - pre_lat==1: bypass, the point is the sample itself and appears the next cycle.
  - Otherwise (divider busy, or out_valid held): drop the window and set overrun. The accumulator still restarts.
- Divider:
  - Restoring, one quotient bit per cycle, ACC_W cycles.
  - busy=1 from the cycle after start through the last iteration.
  - Divisor = pre_lat zero-extended.
- Quotient saturation: quotient > 2^SAMPLE_W-1 → out_data = all ones (unreachable for an average, kept as a guard).
- Latency: window-complete sample to out_valid = ACC_W+1 cycles.
- Handshake:
  - out_valid rises with out_data/out_col stable and holds until out_valid&&out_ready.
  - On accept: out_valid=0; out_col = (out_col==H_RES-1) ? 0 : out_col+1.
  - out_ready while out_valid=0 is ignored.
- States:
  - IDLE: enable=0; outputs hold reset values except out_col and overrun.
  - IDLE→ACCUM on enable.
  - ACCUM→DIV on window start.
  - DIV→OUT after ACC_W iterations.
  - OUT→ACCUM on accept.
  - Accumulation continues in DIV and OUT.
  - Any state→IDLE on enable=0: clears acc, cnt, divider and out_valid; keeps out_col so the roll resumes in place.
- overrun:
  - Set wins over clr_overrun in the same cycle.
  - Cleared only by clr_overrun or reset.
- Reset mid-division: all state returns to reset values immediately (async).

Decomposition:
- Shared package: state encoding (IDLE, ACCUM, DIV, OUT), ACC_W/SAMPLE_W/PRE_W defaults, H_RES.
- One sub-module: seq_divider.
  - Ports: start, dividend, divisor, busy, done, quotient.
  - Iterative restoring, ACC_W cycles.
  - Reusable elsewhere in the datapath.

Test Plan:
- Basic average: prescaler=4, samples 100,200,300,400 one per cycle → out_data=250, out_col=0, out_valid exactly 43 cycles after the 4th sample.
- Bypass: prescaler=0, sample 0xABC → out_data=0xABC one cycle later.
  - Same result with prescaler=1.
- Backpressure and overrun: prescaler=50, out_ready=0 for 200 cycles with a sample every cycle → first point held stable, overrun=1, later windows dropped.
  - Assert clr_overrun with out_ready=1 → overrun=0, next point accepted.
- Column wrap: prescaler=2, 641 accepted points → out_col sequence ..., 639, 0.
- Prescaler change mid-window: prescaler=8, change to 2 after 3 samples → first point is the average of 8 samples, following points average 2.
- Enable drop / reset: enable=0 mid-division → out_valid=0, busy=0 next cycle, out_col kept.
  - rst_n=0 mid-division → all outputs at reset values asynchronously.
